// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared constants, S-box table, subkey schedule and FSM
// encoding for the 64-bit / 256-bit-key / 32-round Feistel decryptor.
package decrypt_pkg;

  localparam int NUM_ROUNDS = 32;
  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 256;

  // Each row lists the outputs for inputs 0..F, left (MSB) to right.
  localparam logic [63:0] SBOX [8] = '{
    64'hFC2A645079ED1B83,
    64'hB634CFE27D805A91,
    64'h1CB0FE65AD489372,
    64'h15ECA70D62B493F8,
    64'h0C89D2AB76354EF1,
    64'h80F325EB1A47C9D6,
    64'h306F1E92D8C4BA57,
    64'h1A68FB04C3597D2E
  };

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // Entry v sits at nibble (15-v) counted from the LSB; 15-v == ~v.
  function automatic logic [3:0] sbox_lu(input logic [2:0] i, input logic [3:0] v);
    logic [63:0] row;
    row = SBOX[i];
    return row[{~v, 2'b00} +: 4];
  endfunction

  // 0-based subkey index for round counter c: K1..K8 forward for the
  // first 8 rounds, then K8..K1 for the remaining 24.
  function automatic logic [2:0] subkey_idx(input logic [4:0] c);
    return (c < 5'd8) ? c[2:0] : (3'd7 - c[2:0]);
  endfunction

endpackage

// File: rtl/decrypt_iter_feistel_f.sv
// feistel_f: combinational Feistel round function.
//   x_i : 32-bit half block
//   k_i : 32-bit subkey
//   f_o : S-box substitution of x_i^k_i, logically shifted left by 11
module feistel_f
  import decrypt_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] k_i,
  output logic [31:0] f_o
);

  logic [31:0] t;
  logic [31:0] s;
  logic        unused_s_hi;

  assign t = x_i ^ k_i;

  // Nibble i counted from the MSB goes through S-box i.
  for (genvar i = 0; i < 8; i++) begin : g_sbox
    assign s[31-4*i -: 4] = sbox_lu(3'(i), t[31-4*i -: 4]);
  end

  // Plain shift, not a rotate: the top 11 bits are discarded.
  assign f_o         = {s[20:0], 11'b0};
  assign unused_s_hi = ^s[31:21];

endmodule

// File: rtl/decrypt_iter.sv
// decrypt_iter: iterative 64-bit Feistel block decryptor, one round per clock.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : ciphertext+key input handshake (accepted in IDLE)
//   ciphertext [64:1]     : encrypted block
//   key [256:1]           : 256-bit key (key[256] unused)
//   out_valid / out_ready : result handshake
//   message [64:1]        : recovered plaintext, held until next result
module decrypt_iter
  import decrypt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLOCK_W:1] ciphertext,
  input  logic [KEY_W:1]   key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLOCK_W:1] message
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       p_q, p_d, q_q, q_d;
  logic [7:0][31:0]  sk_q, sk_d;   // sk_q[0] = K1 ... sk_q[7] = K8
  logic [BLOCK_W:1]  msg_q, msg_d;
  logic [31:0]       f_val;
  logic              unused_key_msb;

  assign unused_key_msb = key[KEY_W];

  feistel_f u_f (
    .x_i (p_q),
    .k_i (sk_q[subkey_idx(cnt_q)]),
    .f_o (f_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    sk_d    = sk_q;
    msg_d   = msg_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          p_d     = ciphertext[64:33];
          q_d     = ciphertext[32:1];
          // K7 and K8 share key bit 32.
          sk_d[0] = key[255:224];
          sk_d[1] = key[223:192];
          sk_d[2] = key[191:160];
          sk_d[3] = key[159:128];
          sk_d[4] = key[127:96];
          sk_d[5] = key[95:64];
          sk_d[6] = key[63:32];
          sk_d[7] = key[32:1];
          cnt_d   = 5'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        p_d   = q_q ^ f_val;
        q_d   = p_q;
        cnt_d = cnt_q + 5'd1;   // wraps to 0 after the last round
        if (cnt_q == 5'(NUM_ROUNDS - 1)) begin
          msg_d   = {p_q, q_q ^ f_val};   // {Q', P'}
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      sk_q    <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      sk_q    <= sk_d;
      msg_q   <= msg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign message   = msg_q;

endmodule

// File: tb/tb_decrypt_iter.sv
module tb_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  ct;
  logic [255:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  message;
  logic [31:0]  fx, fk, fo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decrypt_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ct),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .message    (message)
  );

  feistel_f u_f (.x_i(fx), .k_i(fk), .f_o(fo));

  // ---------------- reference model ----------------
  localparam logic [63:0] SB [8] = '{
    64'hFC2A645079ED1B83, 64'hB634CFE27D805A91, 64'h1CB0FE65AD489372,
    64'h15ECA70D62B493F8, 64'h0C89D2AB76354EF1, 64'h80F325EB1A47C9D6,
    64'h306F1E92D8C4BA57, 64'h1A68FB04C3597D2E
  };

  function automatic logic [31:0] ref_f(input logic [31:0] x, input logic [31:0] k);
    logic [31:0] t;
    logic [63:0] s;
    int nib;
    t = x ^ k;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      nib = int'((t >> (28 - 4*i)) & 32'hF);
      s = (s << 4) | ((SB[i] >> (4 * (15 - nib))) & 64'hF);
    end
    return 32'(s << 11);
  endfunction

  // Kn with the key's bits numbered 256..1; here the vector is 255..0.
  function automatic logic [31:0] subkey(input logic [255:0] k, input int n);
    if (n == 8) return k[31:0];
    return 32'(k >> (223 - 32*(n-1)));
  endfunction

  // enc=0: decrypt schedule; enc=1: the same network with the schedule reversed.
  function automatic logic [63:0] ref_crypt(input logic [63:0] blk, input logic [255:0] k, input bit enc);
    logic [31:0] p, q, t;
    int j, n;
    p = blk[63:32];
    q = blk[31:0];
    for (int r = 0; r < 32; r++) begin
      j = enc ? 32 - r : r + 1;
      n = (j <= 8) ? j : 8 - ((j - 9) % 8);
      t = p;
      p = q ^ ref_f(p, subkey(k, n));
      q = t;
    end
    return {q, p};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd64(), rnd64(), rnd64(), rnd64()};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Called #1 after a rising edge with the DUT idle; accepts on the next edge.
  task automatic start_block(input logic [63:0] c, input logic [255:0] k);
    in_valid = 1'b1;
    ct = c;
    key = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // lat = edges after the accept edge until out_valid; rdy_bad set if in_ready seen high.
  task automatic wait_done(output int lat, output bit rdy_bad);
    lat = 0;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready) rdy_bad = 1'b1;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ct = '0; key = '0;
    fx = '0; fk = '0;
    #3;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (message !== 64'h0) begin n_fail++; $display("FAIL reset_message got %h exp 0", message); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_feistel_f();
    logic [31:0] exp;
    fx = 32'h0; fk = 32'h0; #1;
    n_checks++; if (fo !== 32'h88418800) begin n_fail++; $display("FAIL f_zero got %h exp 88418800", fo); end
    fx = 32'hFFFFFFFF; fk = 32'hFFFFFFFF; #1;
    n_checks++; if (fo !== 32'h88418800) begin n_fail++; $display("FAIL f_ones got %h exp 88418800", fo); end
    for (int i = 0; i < 6; i++) begin
      fx = $urandom(); fk = $urandom(); #1;
      exp = ref_f(fx, fk);
      n_checks++; if (fo !== exp) begin n_fail++; $display("FAIL f_rand x=%h k=%h got %h exp %h", fx, fk, fo, exp); end
    end
  endtask

  task automatic test_round_trip();
    logic [255:0] k;
    logic [63:0] pt, c;
    int lat;
    bit bad;
    k  = {4{64'h0123456789ABCDEF}};
    pt = 64'h0123456789ABCDEF;
    c  = ref_crypt(pt, k, 1'b1);
    start_block(c, k);
    wait_done(lat, bad);
    n_checks++; if (lat != 32) begin n_fail++; $display("FAIL rt_latency got %0d exp 32", lat); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL rt_in_ready got high exp low during RUN/DONE"); end
    n_checks++; if (message !== pt) begin n_fail++; $display("FAIL rt_message got %h exp %h", message, pt); end
    finish_out();
  endtask

  // Random blocks; inputs are scrambled mid-RUN and must not matter.
  task automatic test_random_midrun();
    logic [255:0] k;
    logic [63:0] c, exp;
    int lat;
    bit bad;
    for (int b = 0; b < 4; b++) begin
      k = rnd256(); c = rnd64();
      exp = ref_crypt(c, k, 1'b0);
      start_block(c, k);
      repeat (10) @(posedge clk);
      #1;
      ct = rnd64(); key = rnd256(); in_valid = 1'b1;
      wait_done(lat, bad);
      in_valid = 1'b0;
      lat += 10;
      n_checks++; if (lat != 32) begin n_fail++; $display("FAIL mid_latency blk%0d got %0d exp 32", b, lat); end
      n_checks++; if (bad) begin n_fail++; $display("FAIL mid_in_ready blk%0d got high exp low", b); end
      n_checks++; if (message !== exp) begin n_fail++; $display("FAIL mid_message blk%0d got %h exp %h", b, message, exp); end
      n_checks++; if (ref_crypt(exp, k, 1'b1) !== c) begin n_fail++; $display("FAIL model_inverse blk%0d", b); end
      finish_out();
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] k;
    logic [63:0] c, exp;
    int lat;
    bit bad, hold_bad;
    k = rnd256(); c = rnd64();
    exp = ref_crypt(c, k, 1'b0);
    start_block(c, k);
    wait_done(lat, bad);
    n_checks++; if (message !== exp) begin n_fail++; $display("FAIL bp_message got %h exp %h", message, exp); end
    hold_bad = 1'b0;
    in_valid = 1'b1; ct = rnd64(); key = rnd256();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (message !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
    end
    in_valid = 1'b0;
    n_checks++; if (hold_bad) begin n_fail++; $display("FAIL bp_hold message/out_valid/in_ready changed, last %h %b %b", message, out_valid, in_ready); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); end
    n_checks++; if (message !== exp) begin n_fail++; $display("FAIL bp_after_release got %h exp %h", message, exp); end
  endtask

  task automatic test_reset_mid_run();
    logic [255:0] k;
    logic [63:0] c, exp;
    int lat;
    bit bad;
    start_block(rnd64(), rnd256());
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid flags out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
    n_checks++; if (message !== 64'h0) begin n_fail++; $display("FAIL rst_mid_message got %h exp 0", message); end
    // Hold a new request across reset release: taken on the first edge.
    k = rnd256(); c = rnd64();
    exp = ref_crypt(c, k, 1'b0);
    in_valid = 1'b1; ct = c; key = k;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_accept in_ready got %b exp 0", in_ready); end
    wait_done(lat, bad);
    n_checks++; if (lat != 32 || message !== exp) begin n_fail++; $display("FAIL rst_fresh lat %0d msg %h exp 32 %h", lat, message, exp); end
    finish_out();
  endtask

  task automatic run_one(input logic [63:0] c, input logic [255:0] k, output logic [63:0] res);
    int lat;
    bit bad;
    start_block(c, k);
    wait_done(lat, bad);
    res = (lat < 200) ? message : 64'hx;
    finish_out();
  endtask

  task automatic test_key_bits();
    logic [255:0] ka, kb, kc;
    logic [63:0] c, ra, rb, rc, ea, ec;
    ka = rnd256(); c = rnd64();
    kb = ka ^ (256'h1 << 255);   // key bit 256
    kc = ka ^ (256'h1 << 31);    // key bit 32, shared by K7 and K8
    ea = ref_crypt(c, ka, 1'b0);
    ec = ref_crypt(c, kc, 1'b0);
    run_one(c, ka, ra);
    run_one(c, kb, rb);
    run_one(c, kc, rc);
    n_checks++; if (ra !== ea) begin n_fail++; $display("FAIL kb_a got %h exp %h", ra, ea); end
    n_checks++; if (rb !== ea) begin n_fail++; $display("FAIL kb_msb_unused got %h exp %h", rb, ea); end
    n_checks++; if (rc !== ec) begin n_fail++; $display("FAIL kb_bit32 got %h exp %h", rc, ec); end
    n_checks++; if (rc === ra) begin n_fail++; $display("FAIL kb_bit32_differs got %h equal to %h", rc, ra); end
  endtask

  // out_ready and in_valid held high: one block every 34 cycles.
  task automatic test_back_to_back();
    logic [255:0] k [2];
    logic [63:0] c [2];
    logic [63:0] got [$];
    int acc_cyc [$];
    int cyc;
    bit pre;
    for (int i = 0; i < 2; i++) begin k[i] = rnd256(); c[i] = rnd64(); end
    out_ready = 1'b1; in_valid = 1'b1; ct = c[0]; key = k[0];
    cyc = 0;
    while (got.size() < 2 && cyc < 200) begin
      pre = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (pre) begin
        acc_cyc.push_back(cyc);
        ct = c[1]; key = k[1];
        if (acc_cyc.size() == 2) in_valid = 1'b0;
      end
      if (out_valid) got.push_back(message);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (got.size() != 2 || acc_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_count results %0d accepts %0d exp 2 2", got.size(), acc_cyc.size()); end
    else begin
      n_checks++; if (acc_cyc[1] - acc_cyc[0] != 34) begin n_fail++; $display("FAIL b2b_period got %0d exp 34", acc_cyc[1] - acc_cyc[0]); end
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (got[i] !== ref_crypt(c[i], k[i], 1'b0)) begin n_fail++; $display("FAIL b2b_msg%0d got %h exp %h", i, got[i], ref_crypt(c[i], k[i], 1'b0)); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_feistel_f();
    test_round_trip();
    test_random_midrun();
    test_backpressure();
    test_reset_mid_run();
    test_key_bits();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decrypt_iter.md
# decrypt_iter

Iterative 64-bit block decryptor, the receive-side counterpart of the team's 32-round Feistel encryption core (256-bit key, eight 4-bit S-boxes, XOR key mixing). It accepts one ciphertext block and key over a valid/ready handshake and runs one Feistel round per clock. After 32 rounds it presents the recovered plaintext on a valid/ready output. It sits between the link receive path and the message sink.

## Interface
- No parameters. Block size, key size and round count are fixed at 64, 256 and 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ciphertext and key present
- in_ready  out  1  block can accept input
- ciphertext  in  64 [64:1]  encrypted block
- key  in  256 [256:1]  key; must equal the key used for encryption
- out_valid  out  1  message holds a finished result
- out_ready  in  1  sink accepts result
- message  out  64 [64:1]  recovered plaintext

## Operation
- Subkeys are taken bit-exact to match the encryptor's extraction:
  - K1=key[255:224], K2=key[223:192], K3=key[191:160], K4=key[159:128]
  - K5=key[127:96], K6=key[95:64], K7=key[63:32], K8=key[32:1]
  - key[256] is unused; bit 32 is shared by K7 and K8.
- Round function f(x,k): t=x^k; split t into nibbles n1=t[32:29] … n8=t[4:1]; nibble ni goes through S-box S(i-1).
- S-box contents, hex, listed for inputs 0..F:
  - S0 FC2A645079ED1B83
  - S1 B634CFE27D805A91
  - S2 1CB0FE65AD489372
  - S3 15ECA70D62B493F8
  - S4 0C89D2AB76354EF1
  - S5 80F325EB1A47C9D6
  - S6 306F1E92D8C4BA57
  - S7 1A68FB04C3597D2E
- f result = {s1..s8} shifted left by 11, logical, zero-filled, truncated to 32 bits. This is NOT a rotate.
- Round: (P,Q) <- (Q ^ f(P,k), P).
- Load: P=ciphertext[64:33], Q=ciphertext[32:1].
- After 32 rounds: message={Q,P}.
- Decrypt key order by round j (1..32):
  - j=1..8 use K1..K8.
  - j=9..32 use K8..K1, repeated three times.
  - Index function of round counter c (0..31): c<8 -> K(c+1); otherwise -> K(8-(c mod 8)).
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture P, Q and all 8 subkeys; c=0; go to RUN.
  - RUN: one round per cycle, c++. The round with c==31 writes message={Q',P'} and goes to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Inputs are ignored outside IDLE. Changes to ciphertext or key during RUN do not affect the result.
- in_ready is low in RUN and DONE. There is no overlap of blocks.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, message=0, c=0, internal P/Q/subkeys=0.
- Input handshake at edge E0 (in_valid && in_ready). Rounds execute on edges E1..E32. out_valid=1 is visible after E32.
- Latency is 32 cycles from acceptance to out_valid.
- message is stable while out_valid=1 and stays stable until the next DONE entry.
- Output handshake at edge E (out_valid && out_ready): out_valid=0 and in_ready=1 after E. Next acceptance is no earlier than E+1.
- Best-case throughput is one block per 34 cycles.
- out_ready held high before DONE: result transfers on the first DONE cycle.
- out_ready held low: DONE holds indefinitely and in_ready stays 0.
- rst_n asserted mid-RUN or in DONE: immediate return to reset values; the partial block is discarded.
- in_valid held across reset release: accepted on the first clock edge after rst_n goes high.

## Structure
- Package decrypt_pkg holds:
  - the 8x16 S-box constant table
  - NUM_ROUNDS=32, BLOCK_W=64, KEY_W=256
  - the subkey-index function
  - FSM state encoding
- Sub-module feistel_f is the combinational f(x,k) (S-box lookup plus <<11). It is reusable by a future iterative encryptor.
- Top level contains the FSM, round counter, P/Q registers, subkey register file and output register.

## Test plan
- feistel_f unit: x=0, k=0 -> 32'h88418800. x=32'hFFFFFFFF, k=32'hFFFFFFFF -> 32'h88418800.
- Round trip: key=256'h0123…CDEF (repeated pattern), plaintext 64'h0123456789ABCDEF. Bench golden-model encrypts; the DUT returns exactly 64'h0123456789ABCDEF.
- Latency and handshake: out_valid rises exactly 32 cycles after the accept edge. in_ready=0 throughout RUN and DONE. Changing ciphertext and key mid-RUN does not change the result.
- Backpressure: hold out_ready=0 for 50 cycles after DONE. message is stable and no second block is accepted. Releasing out_ready gives in_ready=1 on the next cycle.
- Reset mid-operation: pull rst_n low at round 17. Outputs are immediately out_valid=0, in_ready=1, message=0. A fresh block then decrypts correctly.
- Key-bit edge case: two keys differing only in key[256] produce identical plaintext. Two keys differing only in key[32] produce different plaintext. Both must match the golden model.
